// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ifu_pkg;

    localparam int          FE_PC_W      = 32;
    localparam int          FE_INST_W    = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef struct packed {
        logic [FE_PC_W-1:0]   pc;
        logic [FE_INST_W-1:0] inst;
        logic                 fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous fetch queue: power-of-2 depth, flush, same-cycle push+pop at any fill level.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  T                           wdata_i,
    input  logic                       pop_i,
    output T                           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic           full, empty, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop_i & ~empty;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wptr] <= wdata_i;
    end

    assign rdata_o = mem[rptr];
    assign count_o = count;

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching IFU: credit-limited sequential AXI-Lite reads into a fetch queue, with redirect flush.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              PC_W      = FE_PC_W,
    parameter int              INST_W    = FE_INST_W,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(IFU_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redir_valid_i,
    input  logic [PC_W-1:0]   redir_pc_i,
    output logic              f_valid_o,
    input  logic              D_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              fault_o,
    output logic              mst_ar_valid_o,
    output logic [PC_W-1:0]   mst_ar_addr_o,
    input  logic              mst_ar_ready_i,
    input  logic              mst_r_valid_i,
    input  logic [INST_W-1:0] mst_r_data_i,
    input  logic [1:0]        mst_r_resp_i,
    output logic              mst_r_ready_o
);

    localparam int OW = $clog2(MAX_OUTST+1);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } entry_t;

    logic            ar_valid_q, stale_q, r_ready_q;
    logic [PC_W-1:0] ar_addr_q, fpc_q, rpc_q;
    logic [OW-1:0]   outst_q, drop_q, outst_nx, drop_nx;
    logic [CW-1:0]   count;
    logic            ar_hs, r_hs, credit, push, pop;
    entry_t          push_e, head_e;

    assign ar_hs  = ar_valid_q & mst_ar_ready_i;
    assign r_hs   = mst_r_valid_i & r_ready_q;
    assign pop    = f_valid_o & D_ready_i;
    // Responses owed to a previous stream, or arriving with a redirect, never reach the queue.
    assign push   = r_hs & (drop_q == '0) & ~redir_valid_i;
    assign push_e = '{pc: rpc_q, inst: mst_r_data_i, fault: (mst_r_resp_i != RESP_OKAY)};
    assign credit = !ar_valid_q && (int'(outst_q) < MAX_OUTST)
                    && (int'(count) + int'(outst_q) < DEPTH);

    always_comb begin
        outst_nx = outst_q;
        if (ar_hs && !r_hs)      outst_nx = outst_q + OW'(1);
        else if (!ar_hs && r_hs) outst_nx = outst_q - OW'(1);

        drop_nx = drop_q;
        if (r_hs && drop_q != '0) drop_nx = drop_nx - OW'(1);
        if (ar_hs && stale_q)     drop_nx = drop_nx + OW'(1);
        // Everything still in flight after this cycle belongs to the old stream.
        if (redir_valid_i)        drop_nx = outst_nx;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= RESET_PC;
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            stale_q    <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            r_ready_q <= 1'b1;
            outst_q   <= outst_nx;
            drop_q    <= drop_nx;

            if (ar_hs) begin
                ar_valid_q <= 1'b0;
                stale_q    <= 1'b0;
            end else if (credit) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= redir_valid_i ? redir_pc_i : fpc_q;
            end

            if (redir_valid_i) begin
                fpc_q <= redir_pc_i;
                rpc_q <= redir_pc_i;
                // A pending AR must keep its address; its response is dropped once it issues.
                if (ar_valid_q && !ar_hs) stale_q <= 1'b1;
            end else begin
                if (ar_hs && !stale_q) fpc_q <= fpc_q + PC_W'(4);
                if (push)              rpc_q <= rpc_q + PC_W'(4);
            end
        end
    end

    ifu_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redir_valid_i),
        .push_i  (push),
        .wdata_i (push_e),
        .pop_i   (pop),
        .rdata_o (head_e),
        .count_o (count)
    );

    assign f_valid_o      = (count != '0);
    assign pc_o           = head_e.pc;
    assign inst_o         = head_e.inst;
    assign fault_o        = head_e.fault;
    assign mst_ar_valid_o = ar_valid_q;
    assign mst_ar_addr_o  = ar_addr_q;
    assign mst_r_ready_o  = r_ready_q;

endmodule
